// File: rtl/pe_row.sv
// Parametrised 1-D systolic MAC row: NTAP stages share a broadcast activation,
// with double-buffered weights, fill tracking, optional ReLU and output clamp.
module pe_row #(
  parameter int NTAP = 5,
  parameter int XW   = 8,
  parameter int WW   = 8,
  parameter int PIW  = 16,
  parameter int POW  = 19
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iWLoad,
  input  logic signed [WW-1:0]  iWData,
  input  logic                  iWCommit,
  input  logic                  iClear,
  input  logic                  iValid,
  input  logic signed [XW-1:0]  iX,
  input  logic signed [PIW-1:0] iPsum,
  input  logic                  iRelu,
  output logic                  oValid,
  output logic signed [POW-1:0] oPsum,
  output logic                  oSat
);

  localparam int PW = XW + WW;
  localparam int AW = ((PIW > PW) ? PIW : PW) + $clog2(NTAP + 1);
  localparam int CW = $clog2(NTAP);
  localparam int EW = ((AW > POW) ? AW : POW) + 1;

  localparam logic signed [EW-1:0] HI = {{(EW-POW+1){1'b0}}, {(POW-1){1'b1}}};
  localparam logic signed [EW-1:0] LO = {{(EW-POW+1){1'b1}}, {(POW-1){1'b0}}};

  // Handshake: iValid qualifies iX/iPsum and there is no backpressure; a sample
  // is consumed on every edge with iValid=1 and iClear=0. oValid is a one-cycle
  // pulse marking oPsum/oSat, which the consumer must take in that cycle.

  logic signed [WW-1:0] s_q [NTAP];
  logic signed [WW-1:0] w_q [NTAP];
  logic signed [AW-1:0] p_q [NTAP];
  logic signed [AW-1:0] p_d [NTAP];
  logic signed [PW-1:0] prod [NTAP];
  logic signed [AW-1:0] prod_ext [NTAP];
  logic [CW-1:0]        cnt_q;
  logic                 last;
  logic                 sat_d;
  logic signed [AW-1:0] r_out;
  logic signed [EW-1:0] r_ext;

  function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] v,
                                                input logic en);
    return (en && v[AW-1]) ? '0 : v;
  endfunction

  function automatic logic over(input logic signed [AW-1:0] v);
    logic signed [EW-1:0] ve;
    ve = {{(EW-AW){v[AW-1]}}, v};
    return (ve > HI) || (ve < LO);
  endfunction

  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      prod[k]     = $signed({{XW{w_q[k][WW-1]}}, w_q[k]}) * $signed({{WW{iX[XW-1]}}, iX});
      prod_ext[k] = {{(AW-PW){prod[k][PW-1]}}, prod[k]};
    end
    p_d[0] = {{(AW-PIW){iPsum[PIW-1]}}, iPsum} + prod_ext[0];
    for (int k = 1; k < NTAP; k++) begin
      p_d[k] = p_q[k-1] + prod_ext[k];
    end
  end

  assign last  = (cnt_q == CW'(NTAP - 1));
  // Saturation flag is judged on the value about to land in the last stage.
  assign sat_d = over(relu(p_d[NTAP-1], iRelu));

  always_comb begin
    r_out = relu(p_q[NTAP-1], iRelu);
    r_ext = {{(EW-AW){r_out[AW-1]}}, r_out};
    if (over(r_out)) begin
      r_ext = r_out[AW-1] ? LO : HI;
    end
    oPsum = r_ext[POW-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int k = 0; k < NTAP; k++) begin
        s_q[k] <= '0;
        w_q[k] <= '0;
        p_q[k] <= '0;
      end
      cnt_q  <= '0;
      oValid <= 1'b0;
      oSat   <= 1'b0;
    end else begin
      if (iWLoad) begin
        s_q[0] <= iWData;
        for (int k = 1; k < NTAP; k++) begin
          s_q[k] <= s_q[k-1];
        end
      end
      if (iWCommit) begin
        for (int k = 0; k < NTAP; k++) begin
          w_q[k] <= s_q[k];
        end
      end
      if (iClear) begin
        for (int k = 0; k < NTAP; k++) begin
          p_q[k] <= '0;
        end
        cnt_q  <= '0;
        oValid <= 1'b0;
        oSat   <= 1'b0;
      end else if (iValid) begin
        for (int k = 0; k < NTAP; k++) begin
          p_q[k] <= p_d[k];
        end
        if (!last) begin
          cnt_q <= cnt_q + CW'(1);
        end
        oValid <= last;
        oSat   <= last && sat_d;
      end else begin
        oValid <= 1'b0;
        oSat   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_row.sv
// Directed bench for pe_row: default build (POW=19) and a clamping build (POW=16)
// driven in lockstep, each checked by its own expected-queue monitor.
module tb_pe_row;

  localparam int NTAP = 5;
  localparam int XW   = 8;
  localparam int WW   = 8;
  localparam int PIW  = 16;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic                  iRST, iWLoad, iWCommit, iClear, iValid, iRelu;
  logic signed [WW-1:0]  iWData;
  logic signed [XW-1:0]  iX;
  logic signed [PIW-1:0] iPsum;

  logic                  oValid_a, oSat_a, oValid_b, oSat_b;
  logic signed [18:0]    oPsum_a;
  logic signed [15:0]    oPsum_b;

  pe_row #(.NTAP(NTAP), .XW(XW), .WW(WW), .PIW(PIW), .POW(19)) u_dut (
    .iCLK(iCLK), .iRST(iRST), .iWLoad(iWLoad), .iWData(iWData),
    .iWCommit(iWCommit), .iClear(iClear), .iValid(iValid), .iX(iX),
    .iPsum(iPsum), .iRelu(iRelu), .oValid(oValid_a), .oPsum(oPsum_a),
    .oSat(oSat_a)
  );

  pe_row #(.NTAP(NTAP), .XW(XW), .WW(WW), .PIW(PIW), .POW(16)) u_dut16 (
    .iCLK(iCLK), .iRST(iRST), .iWLoad(iWLoad), .iWData(iWData),
    .iWCommit(iWCommit), .iClear(iClear), .iValid(iValid), .iX(iX),
    .iPsum(iPsum), .iRelu(iRelu), .oValid(oValid_b), .oPsum(oPsum_b),
    .oSat(oSat_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] exp_q[$];
  logic [16:0] exp16_q[$];
  logic [19:0] e_a;
  logic [16:0] e_b;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push2(input int v19, input logic s19, input int v16, input logic s16);
    exp_q.push_back({s19, 19'(v19)});
    exp16_q.push_back({s16, 16'(v16)});
  endtask

  task automatic push1(input int v);
    push2(v, 1'b0, v, 1'b0);
  endtask

  task automatic drive(input logic v, input int x, input int ps,
                       input logic clr = 1'b0, input logic wl = 1'b0,
                       input int wd = 0, input logic wc = 1'b0);
    iValid   = v;
    iX       = XW'(x);
    iPsum    = PIW'(ps);
    iClear   = clr;
    iWLoad   = wl;
    iWData   = WW'(wd);
    iWCommit = wc;
    @(posedge iCLK);
    #1;
  endtask

  // First word shifted ends in the last stage, so load W5 first.
  task automatic load_weights(input int w1, input int w2, input int w3,
                              input int w4, input int w5);
    drive(0, 0, 0, 0, 1, w5);
    drive(0, 0, 0, 0, 1, w4);
    drive(0, 0, 0, 0, 1, w3);
    drive(0, 0, 0, 0, 1, w2);
    drive(0, 0, 0, 0, 1, w1);
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge iCLK) begin
    if (!iRST && oValid_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_a", 1, 0);
      end else begin
        e_a = exp_q.pop_front();
        check("psum_a", int'(oPsum_a), int'($signed(e_a[18:0])));
        check("sat_a", int'(oSat_a), int'(e_a[19]));
      end
    end
  end

  always @(negedge iCLK) begin
    if (!iRST && oValid_b) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_valid_b", 1, 0);
      end else begin
        e_b = exp16_q.pop_front();
        check("psum_b", int'(oPsum_b), int'($signed(e_b[15:0])));
        check("sat_b", int'(oSat_b), int'(e_b[16]));
      end
    end
  end

  int vpat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
  int xi;
  int mids[5] = '{20, 26, 33, 41, 50};

  initial begin
    iRST = 1'b1; iWLoad = 1'b0; iWData = '0; iWCommit = 1'b0; iClear = 1'b0;
    iValid = 1'b0; iX = '0; iPsum = '0; iRelu = 1'b0;

    // Reset state
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_valid_a", int'(oValid_a), 0);
    check("rst_psum_a", int'(oPsum_a), 0);
    check("rst_sat_a", int'(oSat_a), 0);
    check("rst_valid_b", int'(oValid_b), 0);
    check("rst_psum_b", int'(oPsum_b), 0);
    check("rst_sat_b", int'(oSat_b), 0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;

    // Back-to-back stream, W1..W5 = 1..5
    load_weights(1, 2, 3, 4, 5);
    for (int x = 1; x <= 6; x++) begin
      if (x == 5) push1(55);
      if (x == 6) push1(70);
      drive(1, x, 0);
    end
    drive(0, 0, 0);

    // Same stream with bubbles; garbage on iX during stalls
    drive(0, 0, 0, 1);
    xi = 0;
    for (int i = 0; i < 9; i++) begin
      if (vpat[i] == 1) begin
        xi++;
        if (xi == 5) push1(55);
        if (xi == 6) push1(70);
        drive(1, xi, 0);
      end else begin
        drive(0, 99, 1234);
      end
    end
    drive(0, 0, 0);

    // Extreme operands: fits in 19 bits, clamps in 16 bits
    drive(0, 0, 0, 1);
    load_weights(-128, -128, -128, -128, -128);
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) push2(114687, 1'b0, 32767, 1'b1);
      drive(1, -128, 32767);
    end
    drive(0, 0, 0);

    // Negative result, then ReLU
    drive(0, 0, 0, 1);
    load_weights(-1, -1, -1, -1, -1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push1(-15);
      drive(1, 3, 0);
    end
    drive(0, 0, 0);
    iRelu = 1'b1;
    drive(0, 0, 0);
    push1(0);
    drive(1, 3, 0);
    drive(0, 0, 0);
    iRelu = 1'b0;

    // Clear with a simultaneous valid sample, one sample before priming
    drive(0, 0, 0, 1);
    load_weights(1, 2, 3, 4, 5);
    for (int x = 1; x <= 4; x++) drive(1, x, 0);
    drive(1, 9, 0, 1);
    for (int x = 1; x <= 5; x++) begin
      if (x == 5) push1(55);
      drive(1, x, 0);
    end
    drive(0, 0, 0);

    // Shadow load mid-stream (new W all 10), commit on a stall
    drive(0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      if (i >= 5) push1(15);
      drive(1, 1, 0, 0, (i <= 5), 10);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      push1(mids[i]);
      drive(1, 1, 0);
    end
    drive(0, 0, 0);

    // Reset mid-stream clears weights and pipeline
    iRST = 1'b1;
    drive(1, 1, 0);
    iRST = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i >= 5) push1(7);
      drive(1, 5, 7);
    end
    repeat (3) drive(0, 0, 0);

    check("drain_a", exp_q.size(), 0);
    check("drain_b", exp16_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
